// File: rtl/alu_seq_if.sv
// Command/result bus of alu_seq: operand/opcode channel in, result/flags channel out,
// each with its own valid/ready pair.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               flag_z;
  logic               flag_c;
  logic               flag_v;
  logic               flag_n;
  logic               flag_err;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, out, flag_z, flag_c, flag_v, flag_n, flag_err
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, out, flag_z, flag_c, flag_v, flag_n, flag_err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and flags; single-cycle logic/add/sub and an
// iterative shift-add multiplier producing the full 2*WIDTH product in WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  alu_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_v_q, flag_v_d;
  logic               flag_n_q, flag_n_d;
  logic               flag_err_q, flag_err_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_err;
  logic [WIDTH-1:0]   b_op;
  logic [WIDTH:0]     sum_ext;
  logic [2*WIDTH-1:0] acc_sum;

  assign in_ready      = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_v    = flag_v_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_err  = flag_err_q;

  // Single-cycle datapath; SUB shares the adder as A + ~B + 1, so the adder carry is
  // the inverted borrow and one overflow rule covers both ADD and SUB.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    b_op    = (bus.opcode == OP_SUB) ? ~bus.B : bus.B;
    sum_ext = {1'b0, bus.A} + {1'b0, b_op} + {{WIDTH{1'b0}}, (bus.opcode == OP_SUB)};
    case (bus.opcode)
      OP_NOT: alu_res = ~bus.A;
      OP_OR:  alu_res = bus.A | bus.B;
      OP_XOR: alu_res = bus.A ^ bus.B;
      OP_AND: alu_res = bus.A & bus.B;
      OP_ADD, OP_SUB: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = (bus.opcode == OP_SUB) ? ~sum_ext[WIDTH] : sum_ext[WIDTH];
        alu_v   = (bus.A[WIDTH-1] == b_op[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Control and multiplier step: the accumulator value of the final step is loaded
  // straight into the result so the product appears on the WIDTH-th edge.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    flag_n_d    = flag_n_q;
    flag_err_d  = flag_err_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.opcode == OP_MUL) begin
            mcand_d     = {{WIDTH{1'b0}}, bus.A};
            mplier_d    = bus.B;
            acc_d       = '0;
            cnt_d       = CNT_W'(WIDTH);
            out_valid_d = 1'b0;
            state_d     = MUL;
          end else begin
            out_d       = {{WIDTH{1'b0}}, alu_res};
            flag_z_d    = (alu_res == '0);
            flag_c_d    = alu_c;
            flag_v_d    = alu_v;
            flag_n_d    = alu_res[WIDTH-1];
            flag_err_d  = alu_err;
            out_valid_d = 1'b1;
          end
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_d       = acc_sum;
          flag_z_d    = (acc_sum == '0);
          flag_c_d    = |acc_sum[2*WIDTH-1:WIDTH];
          flag_v_d    = 1'b0;
          flag_n_d    = 1'b0;
          flag_err_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_err_q  <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      flag_n_q    <= flag_n_d;
      flag_err_q  <= flag_err_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized commands checked
// against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int test_count = 0;
  int fail_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int toSigned(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic int modelOut(input logic [2:0] op, input int a, input int b);
    int mask = (1 << W) - 1;
    case (op)
      3'd0:    return (~a) & mask;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return a & b;
      3'd4:    return a * b;
      3'd5:    return (a + b) & mask;
      3'd6:    return (a - b) & mask;
      default: return 0;
    endcase
  endfunction

  // Packed as {err, n, v, c, z}.
  function automatic logic [4:0] modelFlags(input logic [2:0] op, input int a, input int b);
    int  r  = modelOut(op, a, b);
    int  sr;
    logic z, c, v, n, e;
    z = (r == 0);
    c = 1'b0;
    v = 1'b0;
    n = (op != 3'd4) && (((r >> (W - 1)) & 1) == 1);
    e = (op == 3'd7);
    if (op == 3'd5) begin
      c  = (a + b) > ((1 << W) - 1);
      sr = toSigned(a) + toSigned(b);
      v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    end else if (op == 3'd6) begin
      c  = a < b;
      sr = toSigned(a) - toSigned(b);
      v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    end else if (op == 3'd4) begin
      c  = r > ((1 << W) - 1);
    end
    return {e, n, v, c, z};
  endfunction

  function automatic logic [4:0] dutFlags();
    return {bus.flag_err, bus.flag_n, bus.flag_v, bus.flag_c, bus.flag_z};
  endfunction

  // Presents one command and returns just after the edge on which it was accepted.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A        = a;
    bus.B        = b;
    while (!bus.in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = W'($urandom);
    bus.B        = W'($urandom);
    bus.opcode   = 3'($urandom);
  endtask

  // Issues a command with the consumer always ready and checks latency, result and flags.
  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int latency = 0;
    bus.out_ready = 1'b1;
    applyStimulus(op, a, b);
    @(negedge clk);
    while (!bus.out_valid && latency < 3 * W) begin
      if (op == 3'd4) checkOutput("mul_busy_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      latency++;
    end
    checkOutput("out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("latency", 64'(latency), (op == 3'd4) ? 64'(W) : 64'd0);
    checkOutput("out", 64'(bus.out), 64'(modelOut(op, int'(a), int'(b))));
    checkOutput("flags", 64'(dutFlags()), 64'(modelFlags(op, int'(a), int'(b))));
  endtask

  logic [2:0]   tp_op [7];
  logic [W-1:0] tp_a  [7];
  logic [W-1:0] tp_b  [7];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = '0;
    #12;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_out", 64'(bus.out), 64'd0);
    checkOutput("reset_flags", 64'(dutFlags()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);

    runOp(3'd5, 8'hF0, 8'h20);
    runOp(3'd6, 8'h80, 8'h01);
    runOp(3'd6, 8'h01, 8'h02);
    runOp(3'd4, 8'hFF, 8'hFF);
    runOp(3'd4, 8'h0F, 8'h03);

    // Reset three cycles into a multiply must wipe the result immediately.
    bus.out_ready = 1'b1;
    applyStimulus(3'd4, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midmul_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midmul_rst_out", 64'(bus.out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      checkOutput("no_stale_mul", 64'(bus.out_valid), 64'd0);
    end
    runOp(3'd5, 8'h01, 8'h01);

    // Back-to-back single-cycle ops with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tp_op[i] = 3'($urandom_range(0, 6));
      if (tp_op[i] == 3'd4) tp_op[i] = 3'd7;
      tp_a[i] = W'($urandom);
      tp_b[i] = W'($urandom);
    end
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        checkOutput("tput_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("tput_out", 64'(bus.out), 64'(modelOut(tp_op[i-1], int'(tp_a[i-1]), int'(tp_b[i-1]))));
        checkOutput("tput_flags", 64'(dutFlags()), 64'(modelFlags(tp_op[i-1], int'(tp_a[i-1]), int'(tp_b[i-1]))));
      end
      if (i < 6) begin
        bus.in_valid = 1'b1;
        bus.opcode   = tp_op[i];
        bus.A        = tp_a[i];
        bus.B        = tp_b[i];
        #1;
        checkOutput("tput_ready", 64'(bus.in_ready), 64'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    applyStimulus(3'd2, 8'hAA, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_out", 64'(bus.out), 64'd0);
      checkOutput("bp_flags", 64'(dutFlags()), 64'(modelFlags(3'd2, 'hAA, 'hAA)));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode    = 3'd1;
    bus.A         = 8'h0F;
    bus.B         = 8'hF0;
    #1;
    checkOutput("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_new_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("bp_new_out", 64'(bus.out), 64'h00FF);
    checkOutput("bp_new_flags", 64'(dutFlags()), 64'(modelFlags(3'd1, 'h0F, 'hF0)));

    runOp(3'd7, 8'h12, 8'h34);
    runOp(3'd3, 8'h5C, 8'h3A);

    for (int i = 0; i < 80; i++) begin
      runOp(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
    runOp(3'd6, 8'h00, 8'h00);
    runOp(3'd5, 8'h7F, 8'h01);
    runOp(3'd4, 8'h00, 8'hFF);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the 8-bit combinational ALU: same opcode map, generic operand width, registered result with status flags, and a full-width iterative shift-add multiplier in place of the truncated 4-bit product. It sits between an operand/opcode source and a result consumer, with valid/ready on both sides. Logical and add/subtract ops complete in one cycle. Multiply takes WIDTH cycles.

## Interface
- WIDTH, 8, operand width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept a command this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- opcode  in  3  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result this cycle
- out  out  2*WIDTH  result; upper WIDTH bits are zero except for MUL
- flag_z  out  1  out == 0
- flag_c  out  1  carry / borrow / multiply-high-nonzero
- flag_v  out  1  signed overflow (ADD/SUB only)
- flag_n  out  1  out[WIDTH-1] for non-MUL ops; 0 for MUL
- flag_err  out  1  opcode 3'b111 was issued

## Operation
- Opcodes: 000 ~A; 001 A|B; 010 A^B; 011 A&B; 100 A*B (unsigned, full 2*WIDTH product); 101 A+B; 110 A−B; 111 illegal → out=0, flag_err=1, flag_z=1, all other flags 0.
- flag_err=0 for every legal opcode.
- Accept occurs on a rising edge with in_valid && in_ready. A, B and opcode are captured on that edge. Inputs are don't-care at other times.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A new command can be accepted in the same cycle the previous result is consumed.
- States:
  - IDLE: on accept of a non-MUL opcode, out/flags are loaded and out_valid is set on the same edge; state stays IDLE. On accept of MUL, go to MUL. Multiplicand is zero-extended to 2*WIDTH, multiplier goes to a shift register, the accumulator is cleared, the counter is set to WIDTH, and out_valid is cleared.
  - MUL: each cycle, if multiplier LSB==1, add multiplicand to the accumulator. Then shift the multiplicand left 1 and the multiplier right 1, and decrement the counter. When the counter reaches 0 after that step, load out=accumulator and flags, set out_valid, and return to IDLE.
- Width rules:
  - ADD: out = {0, sum[WIDTH-1:0]}; flag_c = carry out of bit WIDTH-1.
  - SUB: computed as A + ~B + 1; flag_c = 1 when A < B unsigned (borrow).
  - flag_v for ADD/SUB uses the standard two's-complement sign rule. flag_v = 0 for all other ops.
  - MUL: flag_c = |out[2W-1:W].
  - Logical ops: flag_c = 0.
- out_valid stays high, and out/flags hold, until out_ready is seen high on a rising edge. out_valid then clears unless a new non-MUL command is accepted on the same edge, in which case the new result replaces the old one.
- in_valid during MUL is ignored, because in_ready=0.
- Reset (async, any state, including mid-multiply): state=IDLE, out_valid=0, out=0, all flags=0, counter=0, internal registers cleared. in_ready goes high combinationally once rst deasserts.

## Timing
- Non-MUL latency: accept at edge k → out_valid high after edge k, result visible in the cycle following k.
- MUL latency: accept at edge k → out_valid high after edge k+WIDTH. in_ready is low from after edge k until out_valid is asserted.
- Sustained throughput: one non-MUL op per cycle with out_ready held high. One MUL per WIDTH+1 cycles.
- All outputs are registered except in_ready, which is combinational from state, out_valid and out_ready.

## Test plan
- ADD, WIDTH=8, A=0xF0, B=0x20, out_ready=1 → one cycle later out=0x0010, flag_c=1, flag_v=0, flag_z=0, flag_n=0.
- SUB, A=0x80, B=0x01 → out=0x007F, flag_v=1, flag_c=0, flag_n=0. Then SUB with A=0x01, B=0x02 → out=0x00FF, flag_c=1, flag_n=1.
- MUL, A=0xFF, B=0xFF → in_ready low for 8 cycles; out_valid after edge k+8 with out=0xFE01, flag_c=1. Then MUL 0x0F*0x03 → 0x002D, flag_c=0.
- Backpressure: issue XOR A=0xAA, B=0xAA with out_ready=0 → out=0x0000, flag_z=1, out_valid held and in_ready=0 for 5 cycles. Raise out_ready together with in_valid OR 0x0F|0xF0 → next cycle out=0x00FF.
- Opcode 111 with A=0x12, B=0x34 → out=0, flag_err=1, flag_z=1. Next legal op clears flag_err.
- Assert rst 3 cycles into MUL 0xFF*0xFF → out_valid=0 and out=0 immediately. After release, ADD 0x01+0x01 → 0x0002 with no stale MUL result.
